// File: rtl/stereo_pkg.sv
// Shared types and sizing helpers for the stereo frame sequencer.
package stereo_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StActive,
    StDrop
  } state_e;

  localparam int unsigned StatsWidth = 16;

  // Counter width for a modulus n; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned col_width(input int unsigned line_words);
    return cnt_width(line_words);
  endfunction

  function automatic int unsigned row_width(input int unsigned frame_lines);
    return cnt_width(frame_lines);
  endfunction

endpackage

// File: rtl/stereo_frame_ctrl_if.sv
// Packed L/R AXI-Stream link (data, valid, ready, end-of-line, start-of-frame).
interface stereo_frame_ctrl_if #(
  parameter int unsigned C_AXIS_LR_TDATA_WIDTH = 32
) ();

  logic [C_AXIS_LR_TDATA_WIDTH-1:0] tdata;
  logic                             tvalid;
  logic                             tready;
  logic                             tlast;
  logic                             tuser;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    output tuser,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    input  tuser,
    output tready
  );

endinterface

// File: rtl/axis_skid_buf.sv
// Two-entry output skid buffer: one-cycle latency, full throughput, registered ready.
module axis_skid_buf #(
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DataWidth-1:0] in_data,
  input  logic                 in_last,
  input  logic                 in_user,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [DataWidth-1:0] out_data,
  output logic                 out_last,
  output logic                 out_user,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int unsigned EntryWidth = DataWidth + 2;

  logic [EntryWidth-1:0] mem_q [2];
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [1:0]            count_q;
  logic [1:0]            count_d;
  logic                  ready_q;
  logic                  push;
  logic                  pop;

  assign push = in_valid && ready_q;
  assign pop  = (count_q != 2'd0) && out_ready;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      ready_q  <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {in_user, in_last, in_data};
      end
      wr_ptr_q <= wr_ptr_q ^ push;
      rd_ptr_q <= rd_ptr_q ^ pop;
      count_q  <= count_d;
      // Ready is a pure register: no combinational path from out_ready.
      ready_q  <= (count_d != 2'd2);
    end
  end

  assign in_ready                       = ready_q;
  assign out_valid                      = (count_q != 2'd0);
  assign {out_user, out_last, out_data} = mem_q[rd_ptr_q];

endmodule

// File: rtl/stereo_frame_ctrl.sv
// Frame sequencer for the packed L/R stream: SOF lock, tlast regeneration, error drop.
// Optional frame/error statistics outputs when STEREO_FRAME_STATS_EN is defined.
module stereo_frame_ctrl
  import stereo_pkg::*;
#(
  parameter int unsigned C_AXIS_LR_TDATA_WIDTH = 32,
  parameter int unsigned C_LINE_WORDS          = 320,
  parameter int unsigned C_FRAME_LINES         = 480
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  enable,
  stereo_frame_ctrl_if.slave    s_axis_lr,
  stereo_frame_ctrl_if.master   m_axis_lr,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  err_eol,
  output logic                  err_sof
`ifdef STEREO_FRAME_STATS_EN
  ,
  output logic [StatsWidth-1:0] frame_count,
  output logic [StatsWidth-1:0] err_count
`endif
);

  localparam int unsigned ColW = col_width(C_LINE_WORDS);
  localparam int unsigned RowW = row_width(C_FRAME_LINES);
  localparam logic [ColW-1:0] ColLast = ColW'(C_LINE_WORDS - 1);
  localparam logic [RowW-1:0] RowLast = RowW'(C_FRAME_LINES - 1);

  state_e                            state_q, state_d;
  logic [ColW-1:0]                   col_q, col_d;
  logic [RowW-1:0]                   row_q, row_d;
  logic                              eol_q, eol_d;
  logic                              sof_q, sof_d;
  logic                              done_q, done_d;
  logic                              accept;
  logic                              in_ready;
  logic                              fwd;
  logic                              fwd_last;
  logic                              fwd_user;
  logic [C_AXIS_LR_TDATA_WIDTH-1:0]  out_data;
  logic                              out_last;
  logic                              out_user;
  logic                              out_valid;

  assign accept          = s_axis_lr.tvalid && in_ready;
  assign s_axis_lr.tready = in_ready;

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    fwd      = 1'b0;
    fwd_last = 1'b0;
    fwd_user = 1'b0;
    eol_d    = 1'b0;
    sof_d    = 1'b0;
    done_d   = 1'b0;
    if (accept) begin
      unique case (state_q)
        StActive: begin
          fwd = 1'b1;
          if (s_axis_lr.tuser && ((col_q != '0) || (row_q != '0))) begin
            // Resync wins over an early tlast on the same beat.
            sof_d    = 1'b1;
            eol_d    = s_axis_lr.tlast && (col_q != ColLast);
            fwd_user = 1'b1;
            col_d    = ColW'(1);
            row_d    = '0;
          end else if (col_q == ColLast) begin
            fwd_last = 1'b1;
            eol_d    = !s_axis_lr.tlast;
            col_d    = '0;
            if (row_q == RowLast) begin
              done_d  = 1'b1;
              row_d   = '0;
              state_d = StIdle;
            end else begin
              row_d = row_q + RowW'(1);
            end
          end else if (s_axis_lr.tlast) begin
            fwd_last = 1'b1;
            eol_d    = 1'b1;
            col_d    = '0;
            row_d    = '0;
            state_d  = StDrop;
          end else begin
            col_d = col_q + ColW'(1);
          end
        end
        default: begin
          // Idle and drop both wait for an enabled SOF beat.
          if (s_axis_lr.tuser && enable) begin
            fwd      = 1'b1;
            fwd_user = 1'b1;
            col_d    = ColW'(1);
            row_d    = '0;
            state_d  = StActive;
          end
        end
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= StIdle;
      col_q   <= '0;
      row_q   <= '0;
      eol_q   <= 1'b0;
      sof_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      eol_q   <= eol_d;
      sof_q   <= sof_d;
      done_q  <= done_d;
    end
  end

  assign busy       = (state_q == StActive);
  assign frame_done = done_q;
  assign err_eol    = eol_q;
  assign err_sof    = sof_q;

  axis_skid_buf #(
    .DataWidth (C_AXIS_LR_TDATA_WIDTH)
  ) u_skid (
    .clk       (aclk),
    .rst       (areset),
    .in_data   (s_axis_lr.tdata),
    .in_last   (fwd_last),
    .in_user   (fwd_user),
    .in_valid  (fwd),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_user  (out_user),
    .out_valid (out_valid),
    .out_ready (m_axis_lr.tready)
  );

  assign m_axis_lr.tdata  = out_data;
  assign m_axis_lr.tlast  = out_last;
  assign m_axis_lr.tuser  = out_user;
  assign m_axis_lr.tvalid = out_valid;

`ifdef STEREO_FRAME_STATS_EN
  logic [StatsWidth-1:0] frame_count_q;
  logic [StatsWidth-1:0] err_count_q;

  always_ff @(posedge aclk) begin
    if (areset) begin
      frame_count_q <= '0;
      err_count_q   <= '0;
    end else begin
      if (done_d) begin
        frame_count_q <= frame_count_q + StatsWidth'(1);
      end
      if ((eol_d || sof_d) && (err_count_q != {StatsWidth{1'b1}})) begin
        err_count_q <= err_count_q + StatsWidth'(1);
      end
    end
  end

  assign frame_count = frame_count_q;
  assign err_count   = err_count_q;
`endif

endmodule

// File: tb/tb_stereo_frame_ctrl.sv
// Randomized self-checking bench for stereo_frame_ctrl with a frame-position reference model.
module tb_stereo_frame_ctrl;

  localparam int unsigned W = 32;
  localparam int L = 4;
  localparam int F = 2;
  localparam int MIdle = 0;
  localparam int MActive = 1;
  localparam int MDrop = 2;

  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
    logic         user;
  } beat_t;

  logic clk = 1'b0;
  logic areset = 1'b1;
  logic enable = 1'b0;
  logic busy, frame_done, err_eol, err_sof;
`ifdef STEREO_FRAME_STATS_EN
  logic [15:0] frame_count, err_count;
  int tot_done, tot_errcyc;
`endif

  always #5 clk = ~clk;

  stereo_frame_ctrl_if #(.C_AXIS_LR_TDATA_WIDTH(W)) s_if ();
  stereo_frame_ctrl_if #(.C_AXIS_LR_TDATA_WIDTH(W)) m_if ();

  stereo_frame_ctrl #(
    .C_AXIS_LR_TDATA_WIDTH (W),
    .C_LINE_WORDS          (L),
    .C_FRAME_LINES         (F)
  ) dut (
    .aclk       (clk),
    .areset     (areset),
    .enable     (enable),
    .s_axis_lr  (s_if),
    .m_axis_lr  (m_if),
    .busy       (busy),
    .frame_done (frame_done),
    .err_eol    (err_eol),
    .err_sof    (err_sof)
`ifdef STEREO_FRAME_STATS_EN
    ,
    .frame_count (frame_count),
    .err_count   (err_count)
`endif
  );

  beat_t in_q[$], exp_q[$], obs_q[$];
  int checks = 0, errors = 0;
  int mode = MIdle, pos = 0;
  int exp_eol, exp_sof, exp_done, obs_eol, obs_sof, obs_done, stall_viol;
  int cyc = 0, first_acc, first_out;
  bit busy_seen, acc_flag, timeout, hold_v;
  beat_t held;

  // Reference: a frame is L*F consecutive words; pos is the word index inside it.
  task automatic model_beat(input beat_t b);
    beat_t o;
    bit e_eol, e_sof;
    int col;
    e_eol = 0; e_sof = 0;
    o.data = b.data; o.last = 1'b0; o.user = 1'b0;
    if (mode != MActive) begin
      if (b.user && enable) begin
        o.user = 1'b1; exp_q.push_back(o); mode = MActive; pos = 1;
      end
    end else begin
      col = pos % L;
      if (b.user && pos != 0) begin
        e_sof = 1; e_eol = b.last && (col != L - 1);
        o.user = 1'b1; exp_q.push_back(o); pos = 1;
      end else if (col == L - 1) begin
        o.last = 1'b1; exp_q.push_back(o); e_eol = !b.last; pos++;
        if (pos == L * F) begin
          exp_done++; mode = MIdle; pos = 0;
`ifdef STEREO_FRAME_STATS_EN
          tot_done++;
`endif
        end
      end else if (b.last) begin
        e_eol = 1; o.last = 1'b1; exp_q.push_back(o); mode = MDrop; pos = 0;
      end else begin
        exp_q.push_back(o); pos++;
      end
    end
    exp_eol += int'(e_eol);
    exp_sof += int'(e_sof);
`ifdef STEREO_FRAME_STATS_EN
    if (e_eol || e_sof) tot_errcyc++;
`endif
  endtask

  // One clock: drive after a falling edge, observe, advance to the next falling edge.
  task automatic cycle(input bit v, input beat_t b, input bit rdy);
    s_if.tvalid = v; s_if.tdata = b.data; s_if.tlast = b.last; s_if.tuser = b.user;
    m_if.tready = rdy;
    #1;
    acc_flag = v && (s_if.tready === 1'b1) && !areset;
    if (acc_flag) begin
      model_beat(b);
      if (first_acc < 0) first_acc = cyc;
    end
    if (hold_v && (m_if.tvalid !== 1'b1 || m_if.tdata !== held.data ||
                   m_if.tlast !== held.last || m_if.tuser !== held.user)) stall_viol++;
    if (m_if.tvalid === 1'b1 && rdy) begin
      obs_q.push_back({m_if.tdata, m_if.tlast, m_if.tuser});
      if (first_out < 0) first_out = cyc;
    end
    hold_v = (m_if.tvalid === 1'b1) && !rdy;
    held = {m_if.tdata, m_if.tlast, m_if.tuser};
    obs_eol += int'(err_eol);
    obs_sof += int'(err_sof);
    obs_done += int'(frame_done);
    busy_seen |= (busy === 1'b1);
    cyc++;
    @(negedge clk);
  endtask

  task automatic send(input int pv, input int pr);
    int idx = 0;
    int budget = 0;
    while (idx < in_q.size() && budget < 2000) begin
      cycle($urandom_range(99) < pv, in_q[idx], $urandom_range(99) < pr);
      if (acc_flag) idx++;
      budget++;
    end
    timeout = (idx < in_q.size());
    repeat (6) cycle(1'b0, '0, 1'b1);
    in_q.delete();
  endtask

  task automatic clear_sb();
    exp_q.delete(); obs_q.delete();
    exp_eol = 0; exp_sof = 0; exp_done = 0;
    obs_eol = 0; obs_sof = 0; obs_done = 0; stall_viol = 0;
    busy_seen = 0; first_acc = -1; first_out = -1;
  endtask

  task automatic add_frame();
    beat_t b;
    for (int p = 0; p < L * F; p++) begin
      b.data = $urandom; b.user = (p == 0); b.last = ((p % L) == L - 1);
      in_q.push_back(b);
    end
  endtask

  task automatic add_garbage(input int n);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.data = $urandom; b.user = 1'b0; b.last = 1'($urandom_range(1));
      in_q.push_back(b);
    end
  endtask

  task automatic model_reset();
    mode = MIdle; pos = 0; hold_v = 0;
`ifdef STEREO_FRAME_STATS_EN
    tot_done = 0; tot_errcyc = 0;
`endif
  endtask

  function automatic int q_diff();
    int n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (obs_q[i] !== exp_q[i]) return i;
    if (obs_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  task automatic test_reset();
    areset = 1; enable = 1; m_if.tready = 1;
    s_if.tvalid = 1; s_if.tdata = $urandom; s_if.tuser = 1; s_if.tlast = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({s_if.tready, m_if.tvalid, m_if.tlast, m_if.tuser, busy, frame_done, err_eol, err_sof}
        !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl: got %b, expected 00000000", {s_if.tready, m_if.tvalid,
               m_if.tlast, m_if.tuser, busy, frame_done, err_eol, err_sof});
    end
    checks++;
    if (m_if.tdata !== '0) begin
      errors++; $display("FAIL reset_tdata: got %h, expected 0", m_if.tdata);
    end
    s_if.tvalid = 0; areset = 0; model_reset();
    @(negedge clk);
    checks++;
    if (s_if.tready !== 1'b1) begin
      errors++; $display("FAIL ready_after_reset: got %b, expected 1", s_if.tready);
    end
  endtask

  task automatic test_clean_frame();
    logic [7:0] users, lasts;
    int d;
    enable = 1; clear_sb(); add_frame(); send(100, 100);
    checks++;
    d = q_diff();
    if (timeout || d != -1) begin
      errors++; $display("FAIL clean_stream: diff at %0d, got %0d beats, expected %0d",
                         d, obs_q.size(), exp_q.size());
    end
    users = '0; lasts = '0;
    for (int i = 0; i < obs_q.size() && i < 8; i++) begin
      users[i] = obs_q[i].user; lasts[i] = obs_q[i].last;
    end
    checks++;
    if ({users, lasts} !== {8'b0000_0001, 8'b1000_1000} || obs_q.size() != 8) begin
      errors++; $display("FAIL clean_flags: got user=%b last=%b n=%0d, expected 00000001 10001000 8",
                         users, lasts, obs_q.size());
    end
    checks++;
    if (obs_done !== 1 || obs_eol + obs_sof !== 0) begin
      errors++; $display("FAIL clean_pulses: got done=%0d err=%0d, expected 1 0",
                         obs_done, obs_eol + obs_sof);
    end
    checks++;
    if (first_out - first_acc !== 1) begin
      errors++; $display("FAIL clean_latency: got %0d, expected 1", first_out - first_acc);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL clean_idle: busy got %b, expected 0", busy);
    end
  endtask

  task automatic test_random_stall();
    int d;
    clear_sb(); add_frame(); add_frame(); send(70, 50);
    checks++;
    d = q_diff();
    if (timeout || d != -1) begin
      errors++; $display("FAIL stall_stream: diff at %0d, got %0d beats, expected %0d",
                         d, obs_q.size(), exp_q.size());
    end
    checks++;
    if (stall_viol !== 0) begin
      errors++; $display("FAIL stall_stable: got %0d changes under stall, expected 0", stall_viol);
    end
    checks++;
    if (obs_done !== 2) begin
      errors++; $display("FAIL stall_done: got %0d, expected 2", obs_done);
    end
  endtask

  task automatic test_garbage();
    int d;
    clear_sb(); add_garbage(5); add_frame(); send(100, 100);
    checks++;
    d = q_diff();
    if (timeout || d != -1 || obs_q.size() != 8) begin
      errors++; $display("FAIL garbage_stream: diff at %0d, got %0d beats, expected 8", d,
                         obs_q.size());
    end
    checks++;
    if (obs_eol + obs_sof !== 0) begin
      errors++; $display("FAIL garbage_err: got %0d, expected 0", obs_eol + obs_sof);
    end
  endtask

  task automatic test_early_tlast();
    beat_t b;
    int d;
    clear_sb();
    b.data = $urandom; b.user = 1; b.last = 0; in_q.push_back(b);
    b.data = $urandom; b.user = 0; b.last = 1; in_q.push_back(b);
    add_garbage(4); add_frame(); send(100, 100);
    checks++;
    d = q_diff();
    if (timeout || d != -1 || obs_q.size() != 10) begin
      errors++; $display("FAIL eol_stream: diff at %0d, got %0d beats, expected 10", d,
                         obs_q.size());
    end
    checks++;
    if (obs_q.size() < 2 || obs_q[1].last !== 1'b1) begin
      errors++; $display("FAIL eol_forced_last: got %0d beats, expected beat1 tlast=1",
                         obs_q.size());
    end
    checks++;
    if (obs_eol !== 1 || obs_sof !== 0 || obs_done !== 1) begin
      errors++; $display("FAIL eol_pulses: got eol=%0d sof=%0d done=%0d, expected 1 0 1",
                         obs_eol, obs_sof, obs_done);
    end
  endtask

  task automatic test_sof_resync();
    beat_t b;
    int d;
    clear_sb();
    for (int p = 0; p < L + 2; p++) begin
      b.data = $urandom; b.user = (p == 0); b.last = ((p % L) == L - 1); in_q.push_back(b);
    end
    add_frame(); send(100, 100);
    checks++;
    d = q_diff();
    if (timeout || d != -1 || obs_q.size() != 14) begin
      errors++; $display("FAIL sof_stream: diff at %0d, got %0d beats, expected 14", d,
                         obs_q.size());
    end
    checks++;
    if (obs_q.size() < 7 || obs_q[6].user !== 1'b1) begin
      errors++; $display("FAIL sof_user: got %0d beats, expected beat6 tuser=1", obs_q.size());
    end
    checks++;
    if (obs_sof !== 1 || obs_eol !== 0 || obs_done !== 1) begin
      errors++; $display("FAIL sof_pulses: got sof=%0d eol=%0d done=%0d, expected 1 0 1",
                         obs_sof, obs_eol, obs_done);
    end
  endtask

  task automatic test_enable_and_reset();
    int d;
    enable = 0; clear_sb(); add_frame(); send(100, 100);
    checks++;
    if (obs_q.size() != 0 || busy_seen) begin
      errors++; $display("FAIL enable_off: got %0d beats busy_seen=%b, expected 0 0",
                         obs_q.size(), busy_seen);
    end
    enable = 1; clear_sb(); add_frame();
    cycle(1'b1, in_q[0], 1'b0);
    cycle(1'b1, in_q[1], 1'b0);
    areset = 1;
    cycle(1'b0, '0, 1'b1);
    checks++;
    if ({s_if.tready, m_if.tvalid, m_if.tlast, m_if.tuser, busy, frame_done, err_eol, err_sof}
        !== 8'h00 || m_if.tdata !== '0) begin
      errors++; $display("FAIL midframe_reset: got ctrl=%b data=%h, expected 0 0",
                         {s_if.tready, m_if.tvalid, m_if.tlast, m_if.tuser, busy, frame_done,
                          err_eol, err_sof}, m_if.tdata);
    end
    areset = 0; model_reset(); in_q.delete();
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);
    clear_sb(); add_frame(); send(100, 100);
    checks++;
    d = q_diff();
    if (timeout || d != -1) begin
      errors++; $display("FAIL reset_recover: diff at %0d, got %0d beats, expected %0d", d,
                         obs_q.size(), exp_q.size());
    end
  endtask

  task automatic test_random();
    beat_t t;
    int base, k, d;
    clear_sb();
    for (int seg = 0; seg < 30; seg++) begin
      enable = ($urandom_range(99) < 80);
      k = $urandom_range(9);
      base = in_q.size();
      if (k <= 4) add_frame();
      else if (k <= 6) add_garbage($urandom_range(1, 6));
      else begin
        add_frame();
        k = base + $urandom_range(1, L * F - 1);
        t = in_q[k];
        if ($urandom_range(1) == 1) t.last = ~t.last;
        else t.user = 1'b1;
        in_q[k] = t;
      end
      send(80, 70);
    end
    checks++;
    d = q_diff();
    if (timeout || d != -1) begin
      errors++; $display("FAIL random_stream: diff at %0d, got %0d beats, expected %0d", d,
                         obs_q.size(), exp_q.size());
    end
    checks++;
    if (obs_eol !== exp_eol || obs_sof !== exp_sof || obs_done !== exp_done) begin
      errors++; $display("FAIL random_pulses: got %0d/%0d/%0d, expected %0d/%0d/%0d",
                         obs_eol, obs_sof, obs_done, exp_eol, exp_sof, exp_done);
    end
    checks++;
    if (stall_viol !== 0) begin
      errors++; $display("FAIL random_stable: got %0d, expected 0", stall_viol);
    end
`ifdef STEREO_FRAME_STATS_EN
    checks++;
    if (frame_count !== 16'(tot_done) || err_count !== 16'(tot_errcyc)) begin
      errors++; $display("FAIL stats_counts: got %0d/%0d, expected %0d/%0d", frame_count,
                         err_count, tot_done, tot_errcyc);
    end
`endif
  endtask

`ifdef STEREO_FRAME_STATS_EN
  task automatic test_stats_saturate();
    beat_t b;
    force dut.err_count_q = 16'hFFFE;
    @(negedge clk);
    release dut.err_count_q;
    enable = 1; clear_sb();
    for (int r = 0; r < 2; r++) begin
      b.data = $urandom; b.user = 1; b.last = 0; in_q.push_back(b);
      b.data = $urandom; b.user = 0; b.last = 1; in_q.push_back(b);
    end
    send(100, 100);
    checks++;
    if (err_count !== 16'hFFFF) begin
      errors++; $display("FAIL stats_saturate: got %h, expected ffff", err_count);
    end
  endtask
`endif

  initial begin
    s_if.tvalid = 0; s_if.tdata = '0; s_if.tlast = 0; s_if.tuser = 0; m_if.tready = 1;
    clear_sb(); model_reset();
    test_reset();
    test_clean_frame();
    test_random_stall();
    test_garbage();
    test_early_tlast();
    test_sof_resync();
    test_enable_and_reset();
    test_random();
`ifdef STEREO_FRAME_STATS_EN
    test_stats_saturate();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
